// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: holds the PC, fetches 32-bit instruction words over a
// req/ack handshake, and latches them into the IR. It also translates the
// MIPS opcode/funct fields into the 6-bit segment index that the microcode
// sequencer dispatches on.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   fetch_req           end-of-segment strobe from the sequencer; starts a fetch
//   pc_load, pc_target  PC redirect (branch/jump taken)
//   mem_req, mem_addr   instruction memory request and address (= pc)
//   mem_ack, mem_rdata  one-cycle response pulse and its instruction word
//   instr, seg_idx      instruction register and its decoded segment index
//   pc                  address of the next fetch
//   stall               fetch outstanding; the sequencer must hold
//   halted              sticky illegal-instruction halt
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       instr,
  output logic [5:0]        seg_idx,
  output logic [ADDR_W-1:0] pc,
  output logic              stall,
  output logic              halted
);

  typedef enum logic [1:0] {IDLE, REQ, HALT} state_t;

  localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(4);
  localparam logic [5:0]        SEG_ILL = 6'h3F;

  state_t              state_q, state_d;
  logic                boot_q;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [5:0]          seg_q, seg_d;
  logic                halted_q, halted_d;
  logic                pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0]   pend_tgt_q, pend_tgt_d;
  logic                redir;
  logic [ADDR_W-1:0]   redir_tgt;
  logic [5:0]          dec;

  function automatic logic [5:0] decode(input logic [31:0] w);
    logic [5:0] r;
    r = SEG_ILL;
    case (w[31:26])
      6'h23: r = 6'd0;
      6'h2B: r = 6'd1;
      6'h04: r = 6'd7;
      6'h02: r = 6'd8;
      6'h00: begin
        case (w[5:0])
          6'h20:   r = 6'd2;
          6'h22:   r = 6'd3;
          6'h24:   r = 6'd4;
          6'h25:   r = 6'd5;
          6'h2A:   r = 6'd6;
          default: r = SEG_ILL;
        endcase
      end
      default: r = SEG_ILL;
    endcase
    return r;
  endfunction

  assign dec = decode(mem_rdata);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    seg_d      = seg_q;
    halted_d   = halted_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    mem_req    = 1'b0;
    stall      = 1'b0;
    // A redirect arriving in the same cycle as the ack still wins over the
    // returned word; the newest target replaces any older pending one.
    redir      = pend_vld_q | pc_load;
    redir_tgt  = pc_load ? pc_target : pend_tgt_q;
    case (state_q)
      IDLE: begin
        // boot_q marks the first cycle out of reset: still stalled, and the
        // first fetch is launched without waiting for fetch_req.
        stall = boot_q;
        if (pc_load) pc_d = pc_target;
        if (fetch_req || boot_q) state_d = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (pc_load) begin
          pend_vld_d = 1'b1;
          pend_tgt_d = pc_target;
        end
        if (mem_ack) begin
          if (redir) begin
            // Word belongs to the abandoned path: drop it and refetch.
            pc_d       = redir_tgt;
            pend_vld_d = 1'b0;
          end else begin
            instr_d = mem_rdata;
            seg_d   = dec;
            pc_d    = pc_q + PC_INC;
            if (dec == SEG_ILL) begin
              halted_d = 1'b1;
              state_d  = HALT;
            end else begin
              state_d  = IDLE;
            end
          end
        end
      end
      HALT:    ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      boot_q     <= 1'b1;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      seg_q      <= '0;
      halted_q   <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      boot_q     <= 1'b0;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      seg_q      <= seg_d;
      halted_q   <= halted_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign instr    = instr_q;
  assign seg_idx  = seg_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, fetch_req, pc_load, mem_ack;
  logic [31:0] pc_target, mem_rdata;
  logic        mem_req, stall, halted;
  logic [31:0] mem_addr, instr, pc;
  logic [5:0]  seg_idx;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_target(pc_target), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr),
    .seg_idx(seg_idx), .pc(pc), .stall(stall), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  seg;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] word;
    logic [5:0]  seg;
    int          dly;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[9];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc, last_instr;
  logic [5:0]  last_seg;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory side: wait for a request, hold off for dly cycles, then ack.
  task automatic serve(input logic [31:0] word, input int dly, input logic [31:0] addr);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      tick;
      n++;
    end
    if (!mem_req) begin
      tests++;
      fails++;
      $display("FAIL req_timeout: mem_req got 0 expected 1");
    end
    chk("mem_addr", mem_addr, addr);
    for (int i = 0; i < dly; i++) begin
      tick;
      chk("hold_req", 32'(mem_req), 32'd1);
      chk("hold_addr", mem_addr, addr);
      chk("hold_stall", 32'(stall), 32'd1);
    end
    mem_ack   = 1'b1;
    mem_rdata = word;
    tick;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic check_out;
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk("instr", instr, e.instr);
      chk("seg_idx", 32'(seg_idx), 32'(e.seg));
      chk("pc", pc, e.pc);
      chk("stall_done", 32'(stall), 32'd0);
      chk("req_done", 32'(mem_req), 32'd0);
      last_instr = e.instr;
      last_seg   = e.seg;
    end
  endtask

  task automatic fetch(input logic [31:0] word, input logic [5:0] seg, input int dly);
    fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    sb.push_back('{word, seg, exp_pc + 32'd4});
    serve(word, dly, exp_pc);
    exp_pc = exp_pc + 32'd4;
    check_out;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'hAC00_0000, 6'd1, 0};
    vecs[1] = '{32'h0000_0020, 6'd2, 1};
    vecs[2] = '{32'h0000_0022, 6'd3, 2};
    vecs[3] = '{32'h0000_0024, 6'd4, 0};
    vecs[4] = '{32'h0000_0025, 6'd5, 1};
    vecs[5] = '{32'h1000_0000, 6'd7, 2};
    vecs[6] = '{32'h0800_0000, 6'd8, 0};
    vecs[7] = '{32'h0043_282A, 6'd6, 1};
    vecs[8] = '{32'h8C00_002A, 6'd0, 0};

    rst_n = 1'b0; fetch_req = 1'b0; pc_load = 1'b0; pc_target = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick; tick;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_seg", 32'(seg_idx), 32'h0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stall", 32'(stall), 32'd1);

    // First fetch is automatic after reset release.
    rst_n = 1'b1;
    tick;
    chk("boot_req", 32'(mem_req), 32'd1);
    exp_pc = 32'h0;
    sb.push_back('{32'h8C01_0004, 6'd0, 32'h4});
    serve(32'h8C01_0004, 0, 32'h0);
    exp_pc = 32'h4;
    check_out;

    // SLT with a 3-cycle memory delay.
    fetch(32'h0022_182A, 6'd6, 3);

    foreach (vecs[i]) fetch(vecs[i].word, vecs[i].seg, vecs[i].dly);

    // Load and fetch in the same cycle: fetch goes to the target.
    pc_load = 1'b1; pc_target = 32'h100; fetch_req = 1'b1;
    tick;
    pc_load = 1'b0; fetch_req = 1'b0;
    sb.push_back('{32'hAC00_0000, 6'd1, 32'h104});
    serve(32'hAC00_0000, 0, 32'h100);
    exp_pc = 32'h104;
    check_out;

    // Redirect while a fetch is outstanding: returned word is dropped.
    fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    chk("redir_addr0", mem_addr, exp_pc);
    pc_load = 1'b1; pc_target = 32'h200;
    tick;
    pc_load = 1'b0;
    chk("redir_hold_addr", mem_addr, exp_pc);
    chk("redir_hold_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick;
    mem_ack = 1'b0;
    chk("redir_instr_kept", instr, last_instr);
    chk("redir_seg_kept", 32'(seg_idx), 32'(last_seg));
    chk("redir_not_halted", 32'(halted), 32'd0);
    chk("redir_req", 32'(mem_req), 32'd1);
    chk("redir_addr", mem_addr, 32'h200);
    chk("redir_stall", 32'(stall), 32'd1);
    sb.push_back('{32'h0000_0020, 6'd2, 32'h204});
    serve(32'h0000_0020, 1, 32'h200);
    exp_pc = 32'h204;
    check_out;

    // Stray ack in IDLE, then PC wrap.
    pc_load = 1'b1; pc_target = 32'hFFFF_FFFC;
    tick;
    pc_load = 1'b0;
    chk("wrap_load_pc", pc, 32'hFFFF_FFFC);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0022;
    tick;
    mem_ack = 1'b0;
    chk("idle_ack_instr", instr, last_instr);
    chk("idle_ack_pc", pc, 32'hFFFF_FFFC);
    chk("idle_ack_req", 32'(mem_req), 32'd0);
    exp_pc = 32'hFFFF_FFFC;
    fetch(32'h8C01_0004, 6'd0, 0);
    chk("wrap_pc", pc, 32'h0);

    // Reset while a fetch is outstanding; late ack must not land.
    fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    tick;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_instr", instr, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hAC00_0000;
    tick;
    rst_n = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("late_ack_instr", instr, 32'h0);
    chk("late_ack_seg", 32'(seg_idx), 32'h0);
    chk("reboot_req", 32'(mem_req), 32'd1);
    chk("reboot_addr", mem_addr, 32'h0);
    sb.push_back('{32'hAC00_0000, 6'd1, 32'h4});
    serve(32'hAC00_0000, 0, 32'h0);
    exp_pc = 32'h4;
    check_out;

    // Illegal opcode halts; everything but reset is ignored afterwards.
    fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    serve(32'hFC00_0000, 0, exp_pc);
    chk("halt_instr", instr, 32'hFC00_0000);
    chk("halt_seg", 32'(seg_idx), 32'h3F);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_req", 32'(mem_req), 32'd0);
    chk("halt_stall", 32'(stall), 32'd0);
    fetch_req = 1'b1; pc_load = 1'b1; pc_target = 32'h300;
    mem_ack = 1'b1; mem_rdata = 32'h8C01_0004;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("halt_hold_req", 32'(mem_req), 32'd0);
      chk("halt_hold_flag", 32'(halted), 32'd1);
      chk("halt_hold_instr", instr, 32'hFC00_0000);
    end
    fetch_req = 1'b0; pc_load = 1'b0; mem_ack = 1'b0;
    rst_n = 1'b0;
    tick;
    chk("unhalt_pc", pc, 32'h0);
    chk("unhalt_flag", 32'(halted), 32'd0);
    chk("unhalt_seg", 32'(seg_idx), 32'h0);
    rst_n = 1'b1;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
